// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between byte-wide memory and the decoder.
// Fetches big-endian 16-bit instructions and buffers up to DEPTH of them.
module instr_prefetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_program,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO
    } state_e;

    state_e        state_q;
    logic [15:0]   fetch_pc_q;
    logic [7:0]    hi_q;
    logic [15:0]   ir_mem_q [DEPTH];
    logic [15:0]   pc_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push;
    logic          pop;
    logic [15:0]   pc_plus1;
    logic [15:0]   pc_plus2;

    assign ir_valid = (count_q != '0);
    assign ir       = ir_mem_q[rd_ptr_q];
    assign ir_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        push     = (state_q == FETCH_LO) && mem_ready;
        pop      = ir_valid && ir_ready;
        count_d  = count_q + CW'(push) - CW'(pop);
        pc_plus1 = fetch_pc_q + 16'd1;
        pc_plus2 = fetch_pc_q + 16'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            hi_q       <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ir_mem_q[i] <= '0;
                pc_mem_q[i] <= '0;
            end
        end else if (pc_load) begin
            // Redirect flushes the queue and drops any in-flight byte
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= pc_load_value;
            mem_addr   <= pc_load_value;
            if (!halt_program) begin
                state_q <= FETCH_HI;
                mem_req <= 1'b1;
            end else begin
                state_q <= IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            if (push) begin
                ir_mem_q[wr_ptr_q] <= {hi_q, mem_rdata};
                pc_mem_q[wr_ptr_q] <= fetch_pc_q;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;

            unique case (state_q)
                IDLE: begin
                    if (!halt_program && (count_q < FULL)) begin
                        state_q  <= FETCH_HI;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc_q;
                    end
                end
                FETCH_HI: begin
                    if (mem_ready) begin
                        hi_q     <= mem_rdata;
                        state_q  <= FETCH_LO;
                        mem_addr <= pc_plus1;
                    end
                end
                FETCH_LO: begin
                    if (mem_ready) begin
                        fetch_pc_q <= pc_plus2;
                        // Room check uses the post-edge occupancy
                        if (!halt_program && (count_d < FULL)) begin
                            state_q  <= FETCH_HI;
                            mem_addr <= pc_plus2;
                        end else begin
                            state_q <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed scenarios
// followed by random traffic against a queue-level reference model.
module tb_instr_prefetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_program;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic        mem_ready;
    logic        ir_ready;
    logic [7:0]  junk;

    logic        mem_req, mem_req2;
    logic [15:0] mem_addr, mem_addr2;
    logic [7:0]  mem_rdata, mem_rdata2;
    logic        ir_valid, ir_valid2;
    logic [15:0] ir, ir2, ir_pc, ir_pc2;

    logic [7:0]  mem [65536];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign mem_rdata  = mem_ready ? mem[mem_addr]  : junk;
    assign mem_rdata2 = mem_ready ? mem[mem_addr2] : junk;

    instr_prefetch_queue #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .halt_program(halt_program),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
        .ir_ready(ir_ready)
    );

    instr_prefetch_queue #(.RESET_PC(16'hFFFF), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .halt_program(halt_program),
        .pc_load(pc_load), .pc_load_value(pc_load_value),
        .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata2),
        .ir_valid(ir_valid2), .ir(ir2), .ir_pc(ir_pc2),
        .ir_ready(ir_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_ir(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {mem[a], mem[b]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_ir", ir, 0);
        chk("rst_irpc", ir_pc, 0);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!ir_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, ir_valid, 1);
    endtask

    // Reference model state for the random phase
    logic [15:0] mq[$];
    logic [15:0] exp_addr;
    bit          lo;
    bit          exp_req;
    logic        p_req, p_ready, p_pcl, p_halt, p_irr;
    logic [15:0] p_pcv;

    initial begin
        rst = 1'b1;
        halt_program = 1'b0;
        pc_load = 1'b0;
        pc_load_value = '0;
        mem_ready = 1'b1;
        ir_ready = 1'b1;
        junk = 8'h5A;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'h56;
        mem[3] = 8'h78;

        // Latency, throughput and wrap at FFFF
        do_reset();
        chk("c1_req", mem_req, 0);
        @(negedge clk);
        chk("c2_req", mem_req, 1);
        chk("c2_addr", mem_addr, 16'h0000);
        chk("c2_addr2", mem_addr2, 16'hFFFF);
        @(negedge clk);
        chk("c3_addr", mem_addr, 16'h0001);
        chk("c3_valid", ir_valid, 0);
        chk("c3_addr2", mem_addr2, 16'h0000);
        @(negedge clk);
        chk("c4_valid", ir_valid, 1);
        chk("c4_ir", ir, 16'h1234);
        chk("c4_irpc", ir_pc, 16'h0000);
        chk("c4_addr", mem_addr, 16'h0002);
        chk("c4_valid2", ir_valid2, 1);
        chk("c4_ir2", ir2, exp_ir(16'hFFFF));
        chk("c4_irpc2", ir_pc2, 16'hFFFF);
        chk("c4_addr2", mem_addr2, 16'h0001);
        @(negedge clk);
        chk("c5_valid", ir_valid, 0);
        chk("c5_addr", mem_addr, 16'h0003);
        @(negedge clk);
        chk("c6_valid", ir_valid, 1);
        chk("c6_ir", ir, 16'h5678);
        chk("c6_irpc", ir_pc, 16'h0002);

        // Fill the queue and pop once
        ir_ready = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        chk("full_req", mem_req, 0);
        chk("full_valid", ir_valid, 1);
        chk("full_irpc", ir_pc, 16'h0000);
        chk("full_ir", ir, exp_ir(16'h0000));
        ir_ready = 1'b1;
        @(negedge clk);
        ir_ready = 1'b0;
        chk("pop_irpc", ir_pc, 16'h0002);
        chk("pop_req", mem_req, 0);
        @(negedge clk);
        chk("refill_req", mem_req, 1);
        chk("refill_addr", mem_addr, 16'h0008);

        // Memory stall in FETCH_HI
        mem_ready = 1'b0;
        ir_ready = 1'b1;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, 16'h0000);
            junk = 8'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("stall_lo_addr", mem_addr, 16'h0001);
        wait_valid("stall_wait");
        chk("stall_ir", ir, exp_ir(16'h0000));

        // Redirect during FETCH_LO with two entries queued
        ir_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge clk);
        chk("redir_pre_addr", mem_addr, 16'h0005);
        chk("redir_pre_valid", ir_valid, 1);
        pc_load = 1'b1;
        pc_load_value = 16'h0100;
        @(negedge clk);
        pc_load = 1'b0;
        chk("redir_valid", ir_valid, 0);
        chk("redir_req", mem_req, 1);
        chk("redir_addr", mem_addr, 16'h0100);
        ir_ready = 1'b1;
        wait_valid("redir_wait");
        chk("redir_irpc", ir_pc, 16'h0100);
        chk("redir_ir", ir, exp_ir(16'h0100));

        // Halt raised in FETCH_HI
        ir_ready = 1'b0;
        do_reset();
        @(negedge clk);
        chk("halt_hi_addr", mem_addr, 16'h0000);
        halt_program = 1'b1;
        @(negedge clk);
        chk("halt_lo_req", mem_req, 1);
        chk("halt_lo_addr", mem_addr, 16'h0001);
        @(negedge clk);
        chk("halt_push", ir_valid, 1);
        chk("halt_irpc", ir_pc, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            chk("halt_idle_req", mem_req, 0);
            @(negedge clk);
        end
        ir_ready = 1'b1;
        @(negedge clk);
        chk("halt_drain", ir_valid, 0);
        chk("halt_drain_req", mem_req, 0);
        halt_program = 1'b0;
        @(negedge clk);
        chk("resume_req", mem_req, 1);
        chk("resume_addr", mem_addr, 16'h0002);

        // Random traffic against the reference model
        ir_ready = 1'b0;
        do_reset();
        mq.delete();
        exp_addr = 16'h0000;
        lo = 1'b0;
        p_req = 1'b0;
        p_ready = mem_ready;
        p_pcl = 1'b0;
        p_pcv = '0;
        p_halt = 1'b0;
        p_irr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int unsigned psize;
            bit lo_was;
            @(negedge clk);
            psize = mq.size();
            lo_was = lo;
            if (p_pcl) begin
                mq.delete();
                exp_addr = p_pcv;
                lo = 1'b0;
                exp_req = !p_halt;
            end else begin
                if (mq.size() != 0 && p_irr) void'(mq.pop_front());
                if (p_req && p_ready) begin
                    if (lo) mq.push_back(exp_addr - 16'd1);
                    exp_addr = exp_addr + 16'd1;
                    lo = !lo;
                end
                if (!p_req) exp_req = !p_halt && (psize < DEPTH);
                else if (!p_ready || !lo_was) exp_req = 1'b1;
                else exp_req = !p_halt && (mq.size() < DEPTH);
            end
            chk("rnd_req", mem_req, exp_req);
            if (exp_req) chk("rnd_addr", mem_addr, exp_addr);
            chk("rnd_valid", ir_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("rnd_irpc", ir_pc, mq[0]);
                chk("rnd_ir", ir, exp_ir(mq[0]));
            end
            mem_ready = ($urandom_range(9) < 7);
            ir_ready = ($urandom_range(9) < 5);
            if ($urandom_range(19) == 0) halt_program = !halt_program;
            pc_load = ($urandom_range(39) == 0);
            pc_load_value = 16'($urandom);
            if ($urandom_range(3) == 0)
                pc_load_value = 16'hFFFC + 16'($urandom_range(3));
            junk = 8'($urandom);
            p_req = mem_req;
            p_ready = mem_ready;
            p_pcl = pc_load;
            p_pcv = pc_load_value;
            p_halt = halt_program;
            p_irr = ir_ready;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Sits directly upstream of the decoder, and replaces the bare fetch path between byte-wide main memory and the decoder.
- Reads 16-bit instructions as two byte reads per instruction: high byte at PC, low byte at PC+1 (big-endian).
- Buffers fetched instructions in a small FIFO and hands them to the decoder over a valid/ready handshake.
- Supports a PC redirect from execute (jumps/branches) and stops fetching while the program is halted.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset.
- DEPTH, 4, number of instruction entries in the queue (power of two, ≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- halt_program  input  1  when high, no new instruction fetch is started.
- pc_load  input  1  redirect request from execute.
- pc_load_value  input  16  redirect target address.
- mem_req  output  1  byte read request to memory.
- mem_addr  output  16  byte address of the request.
- mem_ready  input  1  memory has data this cycle; mem_rdata is valid.
- mem_rdata  input  8  read byte.
- ir_valid  output  1  queue head holds a valid instruction.
- ir  output  16  instruction at queue head ({hi, lo}).
- ir_pc  output  16  address of the instruction's high byte.
- ir_ready  input  1  decoder accepts the head this cycle.

Behaviour:
- Reset:
  - state=IDLE, fetch_pc=RESET_PC, queue count=0, read/write pointers=0.
  - mem_req=0, mem_addr=0, ir_valid=0, ir=0, ir_pc=0.
  - Reset overrides every other input, including mid-request; a mem_ready in the reset cycle is ignored.
- mem_req and mem_addr are registered. While mem_req=1, mem_addr is held stable until a cycle with mem_ready=1. The byte is captured on that edge.
- FSM states:
  - IDLE: on the next edge go to FETCH_HI (mem_req=1, mem_addr=fetch_pc) if !halt_program, count<DEPTH and !pc_load. Otherwise stay.
  - FETCH_HI: on mem_ready, latch hi byte, go to FETCH_LO with mem_addr=fetch_pc+1.
  - FETCH_LO: on mem_ready:
    - push {hi, mem_rdata} with ir_pc=fetch_pc;
    - set fetch_pc=fetch_pc+2;
    - then go back-to-back to FETCH_HI at the new fetch_pc if !halt_program and the post-edge count<DEPTH (counting any same-cycle pop); else go to IDLE with mem_req=0.
- Throughput and latency:
  - With mem_ready tied high: one instruction per 2 cycles.
  - First ir_valid=1 in the 4th cycle after rst deasserts. Cycle 1 is IDLE, cycle 2 is FETCH_HI, cycle 3 is FETCH_LO and pushes at its end.
- Address arithmetic is mod 2^16: fetch_pc=16'hFFFF gives hi at FFFF and lo at 0000, then next fetch_pc=0001. fetch_pc=16'hFFFE gives next 0000.
- Queue:
  - ir_valid = (count!=0). ir and ir_pc come from the head entry.
  - Pop when ir_valid && ir_ready.
  - Push only from FETCH_LO. Room is checked before FETCH_HI starts, so a push never overflows. Push and pop may occur in the same cycle; count is unchanged.
  - ir_ready while empty has no effect.
- Redirect (pc_load=1 at an edge, highest priority after rst):
  - Queue flushed (count=0, pointers=0); any same-cycle pop or push is discarded.
  - fetch_pc=pc_load_value; any in-flight request is abandoned, and mem_ready/mem_rdata in this cycle are ignored.
  - Next state is FETCH_HI at pc_load_value (mem_req=1) if !halt_program, else IDLE (mem_req=0).
  - ir_valid=0 in the cycle after a redirect.
- halt_program:
  - Blocks only the start of a new instruction. An instruction already in FETCH_HI/FETCH_LO completes and is pushed.
  - The queue continues to drain to the decoder.
  - Deasserting halt resumes from IDLE at fetch_pc.

Test Plan:
- Reset, memory [0]=12,[1]=34,[2]=56,[3]=78, mem_ready=1, ir_ready=1 -> ir=16'h1234, ir_pc=0 valid in cycle 4; then ir=16'h5678, ir_pc=2 two cycles later; mem_addr sequence 0,1,2,3.
- ir_ready=0, mem_ready=1 -> after DEPTH=4 instructions, count=4 and mem_req=0, ir holds the first instruction; assert ir_ready for one cycle -> one pop, and fetching of the 5th instruction (addr 8) starts.
- mem_ready stalled 3 cycles during FETCH_HI -> mem_req=1 and mem_addr constant for all 3 stalled cycles; the byte is captured only on the ready cycle.
- Queue holds 2 entries, fetch in FETCH_LO, pc_load=1 with pc_load_value=16'h0100 while mem_ready=1 -> next cycle ir_valid=0, the in-flight byte is discarded, mem_addr=16'h0100; the first instruction delivered has ir_pc=16'h0100.
- RESET_PC=16'hFFFF -> reads addr FFFF then 0000; ir_pc=FFFF; next fetch at 0001.
- halt_program raised during FETCH_HI -> that instruction completes and is pushed, then mem_req=0 stays low; the queue still drains. Lower halt -> fetch resumes at the next sequential PC.
